pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. Each cycle it combines four inputs into one consistent set of hold and flush controls for PC, IF/ID, ID/EX and EX/MEM/WB:
- data-memory wait,
- taken-branch redirect from EX,
- load-use bubble request from the decoder,
- SYNC instruction in ID.

It contains a two-state SYNC drain FSM and two 32-bit performance counters. It sits beside the decoder and drives the `is_stalling` input that gates register-file writes.

## Interface
Parameters:
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `sys_clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `mem_busy` in 1: data memory has not completed the access in MEM; whole pipeline must freeze.
- `branch_taken` in 1: EX resolved a taken branch or jump; the next PC is the target.
- `insert_bubble` in 1: decoder load-use hazard request.
- `is_sync_ins` in 1: the instruction in ID is SYNC.
- `ex_valid` in 1: ID/EX holds a real (non-bubble) instruction.
- `mem_valid` in 1: EX/MEM holds a real instruction.
- `wb_valid` in 1: MEM/WB holds a real instruction.
- `pc_hold` out 1: PC keeps its value.
- `if_id_hold` out 1: IF/ID register keeps its value.
- `if_id_flush` out 1: IF/ID loads a NOP; has priority over hold in the stage register.
- `id_ex_flush` out 1: ID/EX loads a bubble (all control fields zero).
- `back_hold` out 1: ID/EX, EX/MEM and MEM/WB keep their values.
- `is_stalling` out 1: equals `back_hold`; the decoder suppresses its register write while it is 1.
- `sync_done` out 1: single-cycle pulse in the cycle a SYNC is released from ID.
- `stall_cnt` out CNT_W: count of cycles with `pc_hold`=1.
- `flush_cnt` out CNT_W: count of `branch_taken` redirects that were acted on.

## Operation
FSM states:
- RUN: normal flow.
- DRAIN: a SYNC is waiting in ID.
- `empty` = !ex_valid && !mem_valid && !wb_valid.

Per-cycle priority, highest first. All outputs are combinational from the state and these inputs.
1. **`mem_busy`=1:**
   - Outputs: `pc_hold`=`if_id_hold`=`back_hold`=`is_stalling`=1; all flushes 0.
   - FSM state unchanged. `stall_cnt` increments.
2. **`branch_taken`=1:**
   - Outputs: `if_id_flush`=1, `id_ex_flush`=1; all holds 0.
   - FSM goes to RUN, aborting any DRAIN because the SYNC was wrong-path. `flush_cnt` increments.
3. **RUN, `is_sync_ins`=1, `empty`=1:**
   - No hold or flush; `sync_done`=1. State stays RUN.
4. **RUN, `is_sync_ins`=1, `empty`=0:**
   - Outputs: `pc_hold`=`if_id_hold`=1, `id_ex_flush`=1.
   - Next state DRAIN. `stall_cnt` increments.
5. **DRAIN, `empty`=0:**
   - Same outputs as item 4; state stays DRAIN. `stall_cnt` increments.
6. **DRAIN, `empty`=1:**
   - No hold or flush; `sync_done`=1. Next state RUN.
7. **RUN, `insert_bubble`=1:**
   - Outputs: `pc_hold`=`if_id_hold`=1, `id_ex_flush`=1. `stall_cnt` increments.
8. **Otherwise:** all outputs 0.

Additional rules:
- In DRAIN, `insert_bubble` is ignored; the DRAIN outputs already subsume it.
- Counters wrap from all-ones to 0 with no saturation.

## Timing
- Reset (`rst_n`=0 at a rising edge): state becomes RUN and both counters clear to 0.
- Outputs while `rst_n`=0:
  - `if_id_flush`=1 and `id_ex_flush`=1, so the stage registers load NOPs.
  - All holds, `is_stalling` and `sync_done` are 0.
  - `mem_busy`, `branch_taken`, `insert_bubble` and `is_sync_ins` are ignored.
- Reset mid-DRAIN returns to RUN the following cycle with no `sync_done`.
- Latency: control outputs respond in the same cycle as the inputs (zero latency). The FSM and counters update on the rising edge.
- Worst-case SYNC drain with all three back stages valid is 3 stall cycles, followed by the release cycle.
- `mem_busy` during DRAIN extends the drain by the number of busy cycles; the state is held, not reset.

## Test plan
- **Load-use bubble:** `insert_bubble`=1 for 1 cycle in RUN → `pc_hold`=`if_id_hold`=`id_ex_flush`=1 that cycle and `back_hold`=0; `stall_cnt` goes 0→1.
- **Full-pipeline SYNC:**
  - Stimulus: `is_sync_ins`=1 with `ex_valid`/`mem_valid`/`wb_valid`=1/1/1. The bench's stage model clears `ex_valid` 1 cycle later, `mem_valid` 2 cycles later and `wb_valid` 3 cycles later.
  - Response: holds for cycles 0–2, `sync_done`=1 at cycle 3, state returns to RUN, `stall_cnt`=3.
- **Branch aborts DRAIN:** `branch_taken`=1 at cycle 1 of DRAIN → `if_id_flush`=`id_ex_flush`=1, `pc_hold`=0, next state RUN, no `sync_done`, `flush_cnt`=1.
- **Memory freeze dominates:** `mem_busy`=1 together with `branch_taken`=1 and `insert_bubble`=1 for 2 cycles → only the freeze outputs (`is_stalling`=1, no flush) and `flush_cnt` unchanged. When `mem_busy` drops, the branch flush occurs that cycle.
- **Counter wrap:** preload `stall_cnt` to all-ones via force, then apply 1 stall cycle → `stall_cnt`=0.
- **Reset mid-DRAIN:** `rst_n`=0 for 1 cycle during DRAIN → both flushes are 1 and all holds are 0 during reset; afterwards state is RUN, counters are 0 and no `sync_done` pulse occurs.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges memory wait,
// branch redirect, load-use bubbles and SYNC draining into one control set.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             mem_busy,
  input  logic             branch_taken,
  input  logic             insert_bubble,
  input  logic             is_sync_ins,
  input  logic             ex_valid,
  input  logic             mem_valid,
  input  logic             wb_valid,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             back_hold,
  output logic             is_stalling,
  output logic             sync_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              back_empty;
  logic              redirect;

  assign back_empty = !ex_valid && !mem_valid && !wb_valid;

  // NOTE: every output gets a default before the priority chain so no latch is inferred.
  always_comb begin
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    back_hold   = 1'b0;
    sync_done   = 1'b0;
    redirect    = 1'b0;
    state_d     = state_q;

    if (!rst_n) begin
      // Stage registers load NOPs while the core is held in reset.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = ST_RUN;
    end else if (mem_busy) begin
      pc_hold    = 1'b1;
      if_id_hold = 1'b1;
      back_hold  = 1'b1;
    end else if (branch_taken) begin
      // A redirect kills the SYNC in ID as wrong-path, so any drain is abandoned.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      redirect    = 1'b1;
      state_d     = ST_RUN;
    end else if (state_q == ST_DRAIN) begin
      if (back_empty) begin
        sync_done = 1'b1;
        state_d   = ST_RUN;
      end else begin
        pc_hold     = 1'b1;
        if_id_hold  = 1'b1;
        id_ex_flush = 1'b1;
      end
    end else if (is_sync_ins) begin
      if (back_empty) begin
        sync_done = 1'b1;
      end else begin
        pc_hold     = 1'b1;
        if_id_hold  = 1'b1;
        id_ex_flush = 1'b1;
        state_d     = ST_DRAIN;
      end
    end else if (insert_bubble) begin
      pc_hold     = 1'b1;
      if_id_hold  = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  assign is_stalling = back_hold;

  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(pc_hold);
    flush_cnt_d = flush_cnt_q + CNT_W'(redirect);
  end

  // NOTE: reset is sampled on the clock edge (synchronous), and sequential state uses <= only.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic compared against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        mem_busy, branch_taken, insert_bubble, is_sync_ins;
  logic        ex_valid, mem_valid, wb_valid;
  logic        pc_hold, if_id_hold, if_id_flush, id_ex_flush;
  logic        back_hold, is_stalling, sync_done;
  logic [31:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit          m_drain;
  logic [31:0] m_stall, m_flush;
  bit          preload_stall;

  logic [6:0] obs;
  assign obs = {pc_hold, if_id_hold, if_id_flush, id_ex_flush, back_hold, is_stalling, sync_done};

  pipe_hazard_ctrl #(.CNT_W(32)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .mem_busy     (mem_busy),
    .branch_taken (branch_taken),
    .insert_bubble(insert_bubble),
    .is_sync_ins  (is_sync_ins),
    .ex_valid     (ex_valid),
    .mem_valid    (mem_valid),
    .wb_valid     (wb_valid),
    .pc_hold      (pc_hold),
    .if_id_hold   (if_id_hold),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .back_hold    (back_hold),
    .is_stalling  (is_stalling),
    .sync_done    (sync_done),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Expected {pc_hold, if_id_hold, if_id_flush, id_ex_flush, back_hold, is_stalling, sync_done}.
  function automatic logic [6:0] model_out();
    bit freeze, flush, stall, done, empty;
    freeze = 0; flush = 0; stall = 0; done = 0;
    empty  = !(ex_valid || mem_valid || wb_valid);
    if (!rst_n)                     flush = 1;
    else if (mem_busy)              freeze = 1;
    else if (branch_taken)          flush = 1;
    else if (m_drain || is_sync_ins) begin
      if (empty) done = 1; else stall = 1;
    end else if (insert_bubble)     stall = 1;
    return {freeze | stall, freeze | stall, flush, flush | stall, freeze, freeze, done};
  endfunction

  always @(posedge sys_clk) begin
    logic [6:0] e;
    bit empty;
    e     = model_out();
    empty = !(ex_valid || mem_valid || wb_valid);
    if (!rst_n) begin
      m_drain = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_stall = preload_stall ? 32'hFFFF_FFFF : m_stall + 32'(e[6]);
      if (!mem_busy && branch_taken) begin
        m_flush = m_flush + 1;
        m_drain = 0;
      end else if (!mem_busy) begin
        m_drain = (m_drain || is_sync_ins) && !empty;
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_busy = 0; branch_taken = 0; insert_bubble = 0; is_sync_ins = 0;
    ex_valid = 0; mem_valid = 0; wb_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    mem_busy = 1; branch_taken = 1; insert_bubble = 1; is_sync_ins = 1;
    ex_valid = 1; mem_valid = 1; wb_valid = 1;
    @(negedge sys_clk);
    n_checks++;
    if (obs !== 7'b0011000) begin
      n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, 7'b0011000);
    end
    tick();
    rst_n = 1;
    idle_inputs();
    @(negedge sys_clk);
    n_checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    n_checks++;
    if (obs !== 7'b0) begin
      n_fail++; $display("FAIL idle_outputs: got %b want 0000000", obs);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [31:0] base;
    base = stall_cnt;
    insert_bubble = 1;
    @(negedge sys_clk);
    n_checks++;
    if (obs !== 7'b1101000) begin
      n_fail++; $display("FAIL load_use_outputs: got %b want %b", obs, 7'b1101000);
    end
    tick();
    insert_bubble = 0;
    @(negedge sys_clk);
    n_checks++;
    if (stall_cnt !== base + 1) begin
      n_fail++; $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, base + 1);
    end
    tick();
  endtask

  task automatic test_full_sync();
    logic [31:0] base;
    logic [6:0]  want;
    base = stall_cnt;
    is_sync_ins = 1;
    for (int c = 0; c < 4; c++) begin
      ex_valid  = (c < 1);
      mem_valid = (c < 2);
      wb_valid  = (c < 3);
      want = (c < 3) ? 7'b1101000 : 7'b0000001;
      @(negedge sys_clk);
      n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL full_sync_c%0d: got %b want %b", c, obs, want);
      end
      tick();
    end
    idle_inputs();
    @(negedge sys_clk);
    n_checks++;
    if (stall_cnt !== base + 3 || obs !== 7'b0) begin
      n_fail++; $display("FAIL full_sync_end: cnt %0d want %0d, outs %b want 0", stall_cnt, base + 3, obs);
    end
    tick();
  endtask

  task automatic test_branch_abort();
    logic [31:0] base;
    base = flush_cnt;
    is_sync_ins = 1; ex_valid = 1; mem_valid = 1; wb_valid = 1;
    tick();
    branch_taken = 1;
    @(negedge sys_clk);
    n_checks++;
    if (obs !== 7'b0011000) begin
      n_fail++; $display("FAIL branch_abort_outputs: got %b want %b", obs, 7'b0011000);
    end
    tick();
    idle_inputs();
    @(negedge sys_clk);
    n_checks++;
    if (obs !== 7'b0 || flush_cnt !== base + 1) begin
      n_fail++; $display("FAIL branch_abort_after: outs %b want 0, flush_cnt %0d want %0d", obs, flush_cnt, base + 1);
    end
    tick();
  endtask

  task automatic test_mem_freeze();
    logic [31:0] base;
    base = flush_cnt;
    mem_busy = 1; branch_taken = 1; insert_bubble = 1;
    ex_valid = 1; mem_valid = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge sys_clk);
      n_checks++;
      if (obs !== 7'b1100110) begin
        n_fail++; $display("FAIL mem_freeze_c%0d: got %b want %b", c, obs, 7'b1100110);
      end
      tick();
    end
    mem_busy = 0;
    @(negedge sys_clk);
    n_checks++;
    if (obs !== 7'b0011000 || flush_cnt !== base) begin
      n_fail++; $display("FAIL mem_release: outs %b want 0011000, flush_cnt %0d want %0d", obs, flush_cnt, base);
    end
    tick();
    idle_inputs();
    @(negedge sys_clk);
    n_checks++;
    if (flush_cnt !== base + 1) begin
      n_fail++; $display("FAIL mem_release_cnt: got %0d want %0d", flush_cnt, base + 1);
    end
    tick();
  endtask

  task automatic test_counter_wrap();
    @(negedge sys_clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    preload_stall = 1;
    #1;
    release dut.stall_cnt_q;
    tick();
    preload_stall = 0;
    insert_bubble = 1;
    @(negedge sys_clk);
    n_checks++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL wrap_preload: got %h want ffffffff", stall_cnt);
    end
    tick();
    insert_bubble = 0;
    @(negedge sys_clk);
    n_checks++;
    if (stall_cnt !== 0) begin
      n_fail++; $display("FAIL wrap: got %h want 00000000", stall_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    is_sync_ins = 1; ex_valid = 1; mem_valid = 1; wb_valid = 1;
    tick();
    rst_n = 0; insert_bubble = 1;
    @(negedge sys_clk);
    n_checks++;
    if (obs !== 7'b0011000) begin
      n_fail++; $display("FAIL reset_drain_outputs: got %b want %b", obs, 7'b0011000);
    end
    tick();
    rst_n = 1;
    idle_inputs();
    @(negedge sys_clk);
    n_checks++;
    if (obs !== 7'b0 || stall_cnt !== 0 || flush_cnt !== 0) begin
      n_fail++; $display("FAIL reset_drain_after: outs %b want 0, cnt %0d/%0d want 0/0", obs, stall_cnt, flush_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n         = ($urandom_range(0, 49) != 0);
      mem_busy      = ($urandom_range(0, 5) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      insert_bubble = ($urandom_range(0, 3) == 0);
      is_sync_ins   = ($urandom_range(0, 4) == 0);
      ex_valid      = $urandom_range(0, 1) == 1;
      mem_valid     = ($urandom_range(0, 2) == 0);
      wb_valid      = ($urandom_range(0, 2) == 0);
      @(negedge sys_clk);
      n_checks++;
      if (obs !== model_out()) begin
        n_fail++; $display("FAIL random_outputs_%0d: got %b want %b", i, obs, model_out());
      end
      n_checks++;
      if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
        n_fail++; $display("FAIL random_counters_%0d: got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush);
      end
      tick();
    end
    rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    preload_stall = 0;
    m_drain = 0; m_stall = 0; m_flush = 0;
    idle_inputs();
    rst_n = 0;
    #1;
    test_reset();
    test_load_use();
    test_full_sync();
    test_branch_abort();
    test_mem_freeze();
    test_counter_wrap();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
